// File: rtl/param_seq_detector.sv
// Parametrised Mealy serial-pattern detector with loadable pattern, overlap
// control, input-valid qualifier, registered match copy and saturating counter.
module param_seq_detector #(
    parameter int             PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1101,
    parameter int             CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             i,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             clear_cnt,
    output logic             o,
    output logic             o_reg,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int FILL_W = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        ARMED
    } state_t;

    logic [PAT_W-1:0] pat, pat_next;
    logic [PAT_W-2:0] hist, hist_next;
    logic [FILL_W-1:0] fill, fill_next;
    logic [CNT_W-1:0] cnt_next;
    logic [PAT_W-1:0] candidate;
    state_t state;

    // Newest bit appended below the history; dropping the MSB gives the next history.
    assign candidate = {hist, i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat       <= DEFAULT_PAT;
            hist      <= '0;
            fill      <= '0;
            match_cnt <= '0;
            o_reg     <= 1'b0;
        end else begin
            pat       <= pat_next;
            hist      <= hist_next;
            fill      <= fill_next;
            match_cnt <= cnt_next;
            o_reg     <= o;
        end
    end

    always_comb begin
        state     = FILLING;
        o         = 1'b0;
        pat_next  = pat;
        hist_next = hist;
        fill_next = fill;
        cnt_next  = match_cnt;

        if (fill == '0)
            state = EMPTY;
        else if (fill == FILL_FULL)
            state = ARMED;

        o = en & ~pat_load & ~rst & (state == ARMED) & (candidate == pat);

        if (pat_load) begin
            pat_next  = pat_in;
            hist_next = '0;
            fill_next = '0;
        end else if (en) begin
            hist_next = candidate[PAT_W-2:0];
            // Non-overlap mode demands a completely fresh window after a match.
            if (o && !overlap)
                fill_next = '0;
            else if (state != ARMED)
                fill_next = fill + FILL_W'(1);
        end

        if (clear_cnt)
            cnt_next = '0;
        else if (o && (match_cnt != '1))
            cnt_next = match_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_param_seq_detector.sv
// Directed self-checking bench; two instances share stimulus, the second uses
// a 2-bit counter so saturation is reachable.
module tb_param_seq_detector;

    logic       tb_clk;
    logic       rst;
    logic       en;
    logic       i;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       clear_cnt;
    logic       o_a, o_reg_a, o_b, o_reg_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int compared   = 0;
    int mismatched = 0;
    logic exp_q[$];

    param_seq_detector #(.PAT_W(4), .DEFAULT_PAT(4'b1101), .CNT_W(8)) dut_a (
        .clk(tb_clk), .rst(rst), .en(en), .i(i), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clear_cnt(clear_cnt),
        .o(o_a), .o_reg(o_reg_a), .match_cnt(cnt_a)
    );

    param_seq_detector #(.PAT_W(4), .DEFAULT_PAT(4'b1101), .CNT_W(2)) dut_b (
        .clk(tb_clk), .rst(rst), .en(en), .i(i), .overlap(overlap),
        .pat_load(pat_load), .pat_in(pat_in), .clear_cnt(clear_cnt),
        .o(o_b), .o_reg(o_reg_b), .match_cnt(cnt_b)
    );

    initial begin
        tb_clk = 1'b0;
        forever #5 tb_clk = ~tb_clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Called just after a rising edge: drive one cycle, check Mealy o, then o_reg after the edge.
    task automatic applyStimulus(input logic e, input logic b, input logic exp_o);
        logic exp_reg;
        en = e;
        i  = b;
        #2;
        checkOutput("o_a", o_a, exp_o);
        checkOutput("o_b", o_b, exp_o);
        exp_q.push_back(exp_o);
        @(posedge tb_clk);
        #1;
        if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL o_reg_queue observed=empty expected=entry");
        end else begin
            exp_reg = exp_q.pop_front();
            checkOutput("o_reg_a", o_reg_a, exp_reg);
            checkOutput("o_reg_b", o_reg_b, exp_reg);
        end
    endtask

    task automatic doReset();
        en        = 1'b0;
        pat_load  = 1'b0;
        clear_cnt = 1'b0;
        rst       = 1'b1;
        #1;
        checkOutput("rst_o", o_a, 0);
        @(posedge tb_clk);
        #1;
        checkOutput("rst_o_reg", o_reg_a, 0);
        checkOutput("rst_cnt_a", cnt_a, 0);
        checkOutput("rst_cnt_b", cnt_b, 0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; i = 1'b0; overlap = 1'b1;
        pat_load = 1'b0; pat_in = 4'b0000; clear_cnt = 1'b0;
        @(posedge tb_clk);
        #1;
        checkOutput("init_o", o_a, 0);
        checkOutput("init_o_reg", o_reg_a, 0);
        checkOutput("init_cnt", cnt_a, 0);
        rst = 1'b0;

        $display("[TB] basic match");
        applyStimulus(1, 1, 0);
        applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1);
        checkOutput("basic_cnt", cnt_a, 1);

        $display("[TB] overlap on");
        doReset();
        overlap = 1'b1;
        applyStimulus(1, 1, 0); applyStimulus(1, 1, 0); applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1); applyStimulus(1, 1, 0); applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1);
        checkOutput("ovl_cnt", cnt_a, 2);

        $display("[TB] overlap off");
        doReset();
        overlap = 1'b0;
        applyStimulus(1, 1, 0); applyStimulus(1, 1, 0); applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1); applyStimulus(1, 1, 0); applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0);
        checkOutput("novl_cnt", cnt_a, 1);

        $display("[TB] valid gaps");
        doReset();
        overlap = 1'b1;
        applyStimulus(1, 1, 0); applyStimulus(0, 0, 0); applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 0); applyStimulus(0, 0, 0); applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 0); applyStimulus(0, 0, 0); applyStimulus(0, 1, 0);
        applyStimulus(1, 1, 1);
        checkOutput("gap_cnt", cnt_a, 1);

        $display("[TB] pattern load");
        doReset();
        applyStimulus(1, 0, 0); applyStimulus(1, 1, 0); applyStimulus(1, 1, 0);
        pat_load = 1'b1;
        pat_in   = 4'b0110;
        applyStimulus(1, 0, 0);
        pat_load = 1'b0;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 0, 0); applyStimulus(1, 1, 0); applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 1);
        checkOutput("load_cnt", cnt_a, 1);

        $display("[TB] saturation and clear");
        doReset();
        overlap  = 1'b1;
        pat_load = 1'b1;
        pat_in   = 4'b1111;
        applyStimulus(1, 1, 0);
        pat_load = 1'b0;
        applyStimulus(1, 1, 0); checkOutput("sat_cnt1", cnt_b, 0);
        applyStimulus(1, 1, 0); checkOutput("sat_cnt2", cnt_b, 0);
        applyStimulus(1, 1, 0); checkOutput("sat_cnt3", cnt_b, 0);
        applyStimulus(1, 1, 1); checkOutput("sat_cnt4", cnt_b, 1);
        applyStimulus(1, 1, 1); checkOutput("sat_cnt5", cnt_b, 2);
        applyStimulus(1, 1, 1); checkOutput("sat_cnt6", cnt_b, 3);
        applyStimulus(1, 1, 1); checkOutput("sat_cnt7", cnt_b, 3);
        applyStimulus(1, 1, 1); checkOutput("sat_cnt8", cnt_b, 3);
        checkOutput("sat_cnt_a", cnt_a, 5);
        clear_cnt = 1'b1;
        applyStimulus(1, 1, 1);
        clear_cnt = 1'b0;
        checkOutput("clr_cnt_b", cnt_b, 0);
        checkOutput("clr_cnt_a", cnt_a, 0);

        $display("[TB] reset mid-operation");
        pat_load = 1'b1;
        pat_in   = 4'b0110;
        applyStimulus(1, 0, 0);
        pat_load = 1'b0;
        applyStimulus(1, 0, 0); applyStimulus(1, 1, 0); applyStimulus(1, 1, 0);
        applyStimulus(1, 0, 1);
        applyStimulus(1, 0, 0); applyStimulus(1, 1, 0); applyStimulus(1, 1, 0);
        checkOutput("mid_cnt_pre", cnt_a, 1);
        en = 1'b1;
        i  = 1'b0;
        #1;
        checkOutput("mid_o_pre", o_a, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid_o_rst", o_a, 0);
        checkOutput("mid_cnt_rst", cnt_a, 0);
        checkOutput("mid_o_reg_rst", o_reg_a, 0);
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 0); applyStimulus(1, 1, 0); applyStimulus(1, 0, 0);
        applyStimulus(1, 1, 1);
        checkOutput("mid_cnt_post", cnt_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/param_seq_detector.md
Name: param_seq_detector

Overview:
- Parametrised Mealy serial-pattern detector; successor to the fixed 4-bit "1101" detector.
- Features beyond the fixed detector:
  - run-time loadable pattern of width PAT_W
  - overlap / non-overlap match mode
  - input-valid qualifier
  - registered match copy
  - saturating match counter
- Sits on serial bit-stream paths (framing / sync-word detection) ahead of downstream control FSMs.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- DEFAULT_PAT, 4'b1101, pattern loaded at reset; PAT_W bits, MSB = oldest bit.
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  input-valid; i is sampled only on cycles with en=1.
- i  input  1  serial data bit.
- overlap  input  1  1 = overlapping matches allowed; 0 = history restarts after each match.
- pat_load  input  1  load pat_in as the new pattern.
- pat_in  input  PAT_W  new pattern; MSB = first (oldest) bit.
- clear_cnt  input  1  synchronous clear of match_cnt.
- o  output  1  Mealy match: combinational, same cycle as the last pattern bit.
- o_reg  output  1  o registered; one-cycle-late copy.
- match_cnt  output  CNT_W  saturating count of matches.

Behaviour:
- Internal state:
  - pat: PAT_W bits.
  - hist: PAT_W-1 bits; hist[0] = most recent accepted bit.
  - fill: count of accepted bits, saturating at PAT_W-1. Encodes the FSM states EMPTY (0), FILLING (1..PAT_W-2), ARMED (PAT_W-1).
- Reset (rst=1, async, any time including mid-sequence):
  - pat=DEFAULT_PAT, hist=0, fill=0, match_cnt=0, o_reg=0.
  - o=0 while rst=1.
- Match equation (combinational):
  - o = en & ~pat_load & ~rst & (fill==PAT_W-1) & ({hist,i}==pat).
- Clock edge with pat_load=1 (highest priority after rst):
  - pat<=pat_in, hist<=0, fill<=0.
  - The i sample in that cycle is discarded.
  - o=0 that cycle.
- Clock edge with en=1, pat_load=0:
  - hist <= {hist[PAT_W-3:0], i}; for PAT_W=2, hist <= i.
  - fill <= min(fill+1, PAT_W-1).
  - If o=1 and overlap=0: fill <= 0, so a fresh PAT_W bits are required; hist still shifts but is ignored until refilled.
  - If o=1 and overlap=1: fill stays PAT_W-1 (ARMED).
- Clock edge with en=0: hist and fill hold; i ignored; o=0.
- o_reg <= o on every edge; latency exactly 1 cycle.
- match_cnt:
  - clear_cnt=1 -> 0. Clear wins even if o=1 in the same cycle.
  - else if o=1 and match_cnt != all-ones -> +1.
  - all-ones holds (saturates, never wraps).
- overlap is sampled per match cycle; changing it between matches is legal.
- fill never exceeds PAT_W-1; no other wrap conditions exist.
- No X on outputs after reset. i is don't-care when en=0.

Test Plan:
1. Basic match (defaults):
   - Stimulus: rst pulse, then en=1, i=1,1,0,1 on consecutive cycles.
   - Required: o=1 only during the 4th bit cycle; o_reg=1 the following cycle; match_cnt=1.
2. Overlap vs non-overlap:
   - Stimulus: stream 1,1,0,1,1,0,1 with overlap=1.
   - Required: o=1 at bits 4 and 7; match_cnt=2.
   - Repeat with overlap=0 after rst: o=1 at bit 4 only; match_cnt=1.
3. Valid gaps:
   - Stimulus: bits 1,1,0,1 with en=0 cycles inserted between them, and i toggling during those gaps.
   - Required: single match on the final en=1 cycle; o=0 on every en=0 cycle.
4. Pattern load:
   - Stimulus: after bits 0,1,1, pulse pat_load with pat_in=4'b0110, then bit 0.
   - Required: no match, because history was flushed.
   - Then bits 0,1,1,0: o=1 on the last bit.
5. Saturation and clear (CNT_W=2, pat_in=4'b1111, overlap=1):
   - Stimulus: 8 consecutive ones.
   - Required: match_cnt climbs 1, 2, 3 and holds at 3.
   - Then assert clear_cnt on a cycle where o=1: match_cnt=0 next cycle.
6. Reset mid-operation:
   - Stimulus: after pat_load 4'b0110 and bits 0,1,1, assert rst asynchronously between edges.
   - Required: o drops immediately; match_cnt=0; pattern reverts to 1101.
   - Following bit 0 gives no match; a fresh 1,1,0,1 matches.
